text_dot_gen: RTL and testbench

//  Text-mode fetch and dot-shifter stage that sits directly upstream and downstream of char_ram.
//  Per pixel it addresses text screen RAM and drives char_code/scanline/ce into char_ram.
//  It aligns the returned 9-bit glyph row with the fg/bg attributes and shifts out one colour

---
 rtl/text_pkg.sv | 27 ++
 rtl/text_attr_delay.sv | 27 ++
 rtl/text_dot_gen.sv | 183 ++++++++++++++++++
 tb/tb_text_dot_gen.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared definitions for the text-mode fetch / dot-shifter stage:
// screen-word layout, char_ram latency and the screen-word unpack helper.
package text_pkg;

    localparam int CODE_LSB     = 0;
    localparam int CODE_W       = 9;
    localparam int COLOUR_W     = 8;
    localparam int FG_LSB       = CODE_LSB + CODE_W;
    localparam int BG_LSB       = FG_LSB + COLOUR_W;
    localparam int SCR_W        = BG_LSB + COLOUR_W;
    localparam int CHAR_RAM_LAT = 3;

    typedef struct packed {
        logic [COLOUR_W-1:0] bg;
        logic [COLOUR_W-1:0] fg;
        logic [CODE_W-1:0]   code;
    } scr_word_t;

    function automatic scr_word_t unpack_scr(input logic [SCR_W-1:0] w);
        scr_word_t s;
        s.code = w[CODE_LSB +: CODE_W];
        s.fg   = w[FG_LSB +: COLOUR_W];
        s.bg   = w[BG_LSB +: COLOUR_W];
        return s;
    endfunction

endpackage

// File: rtl/text_attr_delay.sv
// Fixed-depth register delay line; keeps attributes and fetch flags in step
// with the external RAM latencies.
module text_attr_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_r [DEPTH];

    // Shift register stages, cleared on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) pipe_r[i] <= '0;
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe_r[i] <= pipe_r[i-1];
        end
    end

    assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/text_dot_gen.sv
// Text-mode fetch and dot shifter: addresses screen RAM, drives char_ram,
// aligns the returned glyph row with its attributes and shifts out colour indices.
module text_dot_gen
    import text_pkg::*;
#(
    parameter int CHAR_W       = 9,
    parameter int SCR_LAT      = 1,
    parameter int BLINK_FRAMES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sof_i,
    input  logic              sol_i,
    input  logic              de_i,
    input  logic [7:0]        cols_i,
    input  logic [3:0]        max_scanline_i,
    input  logic [15:0]       cursor_pos_i,
    input  logic              cursor_en_i,
    output logic [15:0]       scr_adr_o,
    input  logic [SCR_W-1:0]  scr_dat_i,
    output logic              char_ce_o,
    output logic [8:0]        char_code_o,
    output logic [3:0]        scanline_o,
    output logic [3:0]        maxscanline_o,
    input  logic [CHAR_W-1:0] bmp_i,
    output logic [7:0]        pix_o,
    output logic              pix_de_o
);

    localparam int PIX_CNT_W = $clog2(CHAR_W);
    localparam int BLINK_BIT = $clog2(BLINK_FRAMES);
    localparam int ATTR_W    = 3 + 2 * COLOUR_W;
    localparam logic [PIX_CNT_W-1:0] PIX_LAST  = PIX_CNT_W'(CHAR_W - 1);
    localparam logic [PIX_CNT_W-1:0] PIX_ONE   = PIX_CNT_W'(1);
    localparam logic [BLINK_BIT:0]   BLINK_ONE = (BLINK_BIT + 1)'(1);

    logic                 synced_r, de_d_r;
    logic [15:0]          row_base_r;
    logic [7:0]           col_r;
    logic [3:0]           scanline_r;
    logic [PIX_CNT_W-1:0] pix_cnt_r;
    logic [BLINK_BIT:0]   blink_cnt_r;
    logic [CHAR_W-1:0]    shifter_r, stage_bits_r;
    logic [7:0]           cur_fg_r, cur_bg_r, stage_fg_r, stage_bg_r;

    logic        synced_s, de_fall_s, dot_slot_s, fetch_s, blank_s, hit_s;
    logic [7:0]  col_eff_s;
    logic [15:0] base_s, fetch_adr_s;
    logic [3:0]  scan_eff_s;
    logic        f_valid_s, f_blank_s, f_hit_s;
    logic        a_valid_s, a_blank_s, a_hit_s;
    logic [7:0]  a_fg_s, a_bg_s;
    logic [ATTR_W-1:0] a_din_s;
    scr_word_t   scr_word_s;

    // Fetch decision; a coincident sof_i already counts as row 0, scanline 0
    always_comb begin
        synced_s    = synced_r | sof_i;
        de_fall_s   = de_d_r & ~de_i;
        dot_slot_s  = de_i & (pix_cnt_r == '0);
        fetch_s     = synced_s & (sol_i | dot_slot_s);
        col_eff_s   = sol_i ? 8'h00 : col_r;
        base_s      = sof_i ? 16'h0000 : row_base_r;
        scan_eff_s  = sof_i ? 4'h0 : scanline_r;
        fetch_adr_s = base_s + {8'h00, col_eff_s};
        blank_s     = (col_eff_s == cols_i);
        hit_s       = cursor_en_i & blink_cnt_r[BLINK_BIT] & ~blank_s &
                      (fetch_adr_s == cursor_pos_i) &
                      (({1'b0, scan_eff_s} + 5'd2) >= {1'b0, max_scanline_i});
    end

    text_attr_delay #(.WIDTH(3), .DEPTH(SCR_LAT)) u_fetch_dly (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .din   ({fetch_s, blank_s, hit_s}),
        .dout  ({f_valid_s, f_blank_s, f_hit_s})
    );

    // Attributes enter the delay line together with the char_ram request
    always_comb begin
        scr_word_s = unpack_scr(scr_dat_i);
        a_din_s    = {f_valid_s, f_blank_s, f_hit_s,
                      f_blank_s ? 8'h00 : scr_word_s.bg,
                      f_blank_s ? 8'h00 : scr_word_s.fg};
    end

    text_attr_delay #(.WIDTH(ATTR_W), .DEPTH(CHAR_RAM_LAT)) u_attr_dly (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .din   (a_din_s),
        .dout  ({a_valid_s, a_blank_s, a_hit_s, a_bg_s, a_fg_s})
    );

    // Frame/line counters, sync flag and blink counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            synced_r    <= 1'b0;
            de_d_r      <= 1'b0;
            row_base_r  <= 16'h0000;
            scanline_r  <= 4'h0;
            blink_cnt_r <= '0;
        end else begin
            synced_r <= synced_s;
            de_d_r   <= de_i;
            if (sof_i) begin
                row_base_r  <= 16'h0000;
                scanline_r  <= 4'h0;
                blink_cnt_r <= blink_cnt_r + BLINK_ONE;
            end else if (de_fall_s) begin
                if (({1'b0, scanline_r} + 5'd1) >= {1'b0, max_scanline_i}) begin
                    scanline_r <= 4'h0;
                    row_base_r <= row_base_r + {8'h00, cols_i};
                end else begin
                    scanline_r <= scanline_r + 4'd1;
                end
            end
        end
    end

    // Screen address, column counter and char_ram drive
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scr_adr_o     <= 16'h0000;
            col_r         <= 8'h00;
            char_ce_o     <= 1'b0;
            char_code_o   <= 9'h000;
            scanline_o    <= 4'h0;
            maxscanline_o <= 4'h0;
        end else begin
            if (fetch_s & ~blank_s) begin
                scr_adr_o <= fetch_adr_s;
                col_r     <= col_eff_s + 8'd1;
            end else if (sol_i) begin
                col_r <= 8'h00;
            end
            char_ce_o <= f_valid_s & ~f_blank_s;
            if (f_valid_s & ~f_blank_s) char_code_o <= scr_word_s.code;
            if (sol_i) scanline_o <= scan_eff_s;
            maxscanline_o <= max_scanline_i;
        end
    end

    // Staging register: glyph row plus its attributes, blanked or cursor-filled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_bits_r <= '0;
            stage_fg_r   <= 8'h00;
            stage_bg_r   <= 8'h00;
        end else if (a_valid_s) begin
            stage_bits_r <= a_blank_s ? '0 : (a_hit_s ? '1 : bmp_i);
            stage_fg_r   <= a_fg_s;
            stage_bg_r   <= a_bg_s;
        end
    end

    // Dot shifter; the first dot of a glyph is taken straight from staging
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_cnt_r <= '0;
            shifter_r <= '0;
            cur_fg_r  <= 8'h00;
            cur_bg_r  <= 8'h00;
            pix_o     <= 8'h00;
        end else if (!de_i) begin
            pix_cnt_r <= '0;
            pix_o     <= 8'h00;
        end else begin
            pix_cnt_r <= (pix_cnt_r == PIX_LAST) ? '0 : pix_cnt_r + PIX_ONE;
            if (dot_slot_s) begin
                shifter_r <= {stage_bits_r[CHAR_W-2:0], 1'b0};
                cur_fg_r  <= stage_fg_r;
                cur_bg_r  <= stage_bg_r;
                pix_o     <= synced_r ? (stage_bits_r[CHAR_W-1] ? stage_fg_r : stage_bg_r) : 8'h00;
            end else begin
                shifter_r <= {shifter_r[CHAR_W-2:0], 1'b0};
                pix_o     <= synced_r ? (shifter_r[CHAR_W-1] ? cur_fg_r : cur_bg_r) : 8'h00;
            end
        end
    end

    assign pix_de_o = de_d_r;

endmodule

// File: tb/tb_text_dot_gen.sv
// Directed bench for text_dot_gen with behavioural screen RAM and char_ram models;
// expected dots are queued when de_i is driven and checked as pix_de_o presents them.
module tb_text_dot_gen;

    logic        clk_i = 1'b0;
    logic        rst_ni, sof_i, sol_i, de_i, cursor_en_i, char_ce_o, pix_de_o;
    logic [7:0]  cols_i, pix_o;
    logic [3:0]  max_scanline_i, scanline_o, maxscanline_o;
    logic [15:0] cursor_pos_i, scr_adr_o;
    logic [24:0] scr_dat_i;
    logic [8:0]  char_code_o, bmp_i;
    logic [42:0] outs_s;

    logic [24:0] mem [64];
    logic        cr_ce;
    logic [8:0]  cr_code;
    logic [7:0]  sb [$];

    int          errors = 0;
    int          checks = 0;
    bit          ce_forbid = 1'b0;
    logic [15:0] m_row;
    int          m_scan, m_blink;
    bit          m_synced;

    always #5 clk_i = ~clk_i;

    text_dot_gen dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sof_i(sof_i), .sol_i(sol_i), .de_i(de_i),
        .cols_i(cols_i), .max_scanline_i(max_scanline_i), .cursor_pos_i(cursor_pos_i),
        .cursor_en_i(cursor_en_i), .scr_adr_o(scr_adr_o), .scr_dat_i(scr_dat_i),
        .char_ce_o(char_ce_o), .char_code_o(char_code_o), .scanline_o(scanline_o),
        .maxscanline_o(maxscanline_o), .bmp_i(bmp_i), .pix_o(pix_o), .pix_de_o(pix_de_o)
    );

    assign outs_s = {scr_adr_o, char_ce_o, char_code_o, scanline_o, maxscanline_o, pix_o, pix_de_o};

    // Screen RAM with one clock of read latency from the fetch
    assign scr_dat_i = mem[scr_adr_o[5:0]];

    function automatic logic [8:0] glyph(input logic [8:0] c);
        if (c == 9'h041) return 9'h1AA;
        return c ^ 9'h0C3;
    endfunction

    // char_ram: bitmap is sampled by the DUT three clocks after ce
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cr_ce <= 1'b0; cr_code <= 9'h000; bmp_i <= 9'h000;
        end else begin
            cr_ce   <= char_ce_o;
            cr_code <= char_code_o;
            if (cr_ce) bmp_i <= glyph(cr_code);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer and idle/ce monitors
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (pix_de_o) begin
                if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
                else chk("pix", pix_o, sb.pop_front());
            end else begin
                chk("pix_idle", pix_o, 8'h00);
            end
            if (ce_forbid) chk("ce_before_sof", char_ce_o, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk_i); #1;
    endtask

    function automatic bit blink_ph();
        return ((m_blink >> 4) & 1) != 0;
    endfunction

    function automatic logic [7:0] exp_dot(input int j, input bit ph0);
        int k, b;
        logic [15:0] a;
        logic [24:0] w;
        logic [8:0]  bits;
        bit ph, hit;
        k = j / 9;
        b = j % 9;
        if (!m_synced || k >= int'(cols_i)) return 8'h00;
        a    = m_row + 16'(k);
        w    = mem[a[5:0]];
        ph   = (k == 0) ? ph0 : blink_ph();
        hit  = cursor_en_i && ph && (a == cursor_pos_i) && (m_scan + 2 >= int'(max_scanline_i));
        bits = hit ? 9'h1FF : glyph(w[8:0]);
        return bits[8-b] ? w[16:9] : w[24:17];
    endfunction

    task automatic model_sof();
        m_blink++;
        m_row = 16'h0000; m_scan = 0; m_synced = 1'b1;
    endtask

    task automatic run_line(input bit with_sof, input int n_de);
        bit ph0;
        logic [15:0] row_s;
        ph0 = blink_ph();
        sof_i = with_sof; sol_i = 1'b1;
        if (with_sof) model_sof();
        row_s = m_row;
        tick();
        sof_i = 1'b0; sol_i = 1'b0;
        chk("adr_at_sol", scr_adr_o, m_synced ? m_row : 16'h0000);
        chk("ce_at_fetch", char_ce_o, 1'b0);
        tick();
        chk("ce_lat", char_ce_o, m_synced);
        if (m_synced) chk("char_code", char_code_o, mem[m_row[5:0]][8:0]);
        chk("scanline", scanline_o, 4'(m_scan));
        chk("maxscanline", maxscanline_o, 4'd8);
        tick();
        chk("ce_one_clk", char_ce_o, 1'b0);
        repeat (3) tick();
        for (int j = 0; j < n_de; j++) begin
            de_i = 1'b1;
            sb.push_back(exp_dot(j, ph0));
            tick();
        end
        de_i = 1'b0;
        tick();
        if (m_scan + 1 >= 8) begin
            m_scan = 0; m_row = m_row + 16'(cols_i);
        end else begin
            m_scan++;
        end
        chk("adr_line_end", scr_adr_o, m_synced ? row_s + 16'(cols_i) - 16'd1 : 16'h0000);
        repeat (2) tick();
    endtask

    task automatic sof_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            sof_i = 1'b1; model_sof(); tick();
            sof_i = 1'b0; tick();
        end
    endtask

    initial begin
        bit ph0;
        rst_ni = 1'b0; sof_i = 1'b0; sol_i = 1'b0; de_i = 1'b0;
        cols_i = 8'd2; max_scanline_i = 4'd8; cursor_pos_i = 16'd1; cursor_en_i = 1'b0;
        m_row = 16'h0000; m_scan = 0; m_blink = 0; m_synced = 1'b0;
        mem[0] = {8'h01, 8'h0F, 9'h041};
        mem[1] = {8'h22, 8'h33, 9'h042};
        mem[2] = {8'h44, 8'h55, 9'h043};
        mem[3] = {8'h66, 8'h77, 9'h044};
        for (int i = 4; i < 64; i++) mem[i] = {8'(i * 3 + 1), 8'(i * 5 + 2), 9'(i)};

        repeat (3) tick();
        chk("reset_outputs", outs_s, 43'h0);
        @(negedge clk_i); rst_ni = 1'b1;
        tick();

        // First frame line: glyph 0x1AA with fg 0F / bg 01, then 8 more lines to wrap
        run_line(1'b1, 18);
        for (int i = 0; i < 8; i++) run_line(1'b0, 18);

        // Over-long de with coincident sof/sol
        run_line(1'b1, 30);

        // Reset in the middle of an active line
        ph0 = blink_ph();
        sof_i = 1'b1; sol_i = 1'b1; model_sof(); tick();
        sof_i = 1'b0; sol_i = 1'b0;
        repeat (5) tick();
        for (int j = 0; j < 6; j++) begin
            de_i = 1'b1; sb.push_back(exp_dot(j, ph0)); tick();
        end
        @(negedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        chk("midline_reset_outputs", outs_s, 43'h0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i); #1;
        de_i = 1'b0; rst_ni = 1'b1;
        m_row = 16'h0000; m_scan = 0; m_blink = 0; m_synced = 1'b0;
        chk("sb_drained_at_reset", 32'(sb.size()), 32'd0);
        tick();
        ce_forbid = 1'b1;
        run_line(1'b0, 18);
        run_line(1'b0, 18);
        ce_forbid = 1'b0;

        // Cursor with blink phase on, then off
        cursor_en_i = 1'b1;
        sof_pulses(16);
        run_line(1'b1, 18);
        for (int i = 0; i < 7; i++) run_line(1'b0, 18);
        sof_pulses(15);
        run_line(1'b1, 18);
        for (int i = 0; i < 7; i++) run_line(1'b0, 18);

        repeat (4) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
